// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the multiply/divide unit.
// Holds the md_op encodings used by the decoder, the hazard unit and md_unit,
// the default busy-window lengths, and the controller state encoding.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Ops that open a busy window (mult/multu/div/divu occupy codes 0..3).
  function automatic logic is_timed_op(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request / HI-LO result bundle of the multiply/divide unit.
//   master (pipeline side): drives start, md_op, src_a, src_b, md_use_D;
//                           receives HI, LO, busy, stall_req.
//   slave  (md_unit):       the mirror image.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_D;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        stall_req;

  modport master (
    output start, md_op, src_a, src_b, md_use_D,
    input  HI, LO, busy, stall_req
  );

  modport slave (
    input  start, md_op, src_a, src_b, md_use_D,
    output HI, LO, busy, stall_req
  );
endinterface

// File: rtl/md_unit_datapath.sv
// md_datapath: combinational arithmetic for md_unit.
//   op       : md_op code (selects signed vs unsigned interpretation)
//   a, b     : rs / rt operands
//   prod     : full 64-bit product
//   quot/rem : quotient (truncated toward zero) and remainder (dividend's sign)
//   div_zero : divisor is zero; quot/rem are then meaningless
module md_datapath
  import md_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        sgn_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;

  // Sign/magnitude arithmetic: divide magnitudes, then restore signs. This
  // makes 0x80000000 / -1 come out as 0x80000000 rem 0 with no special case.
  always_comb begin
    sgn_s    = (op == MD_MULT) || (op == MD_DIV);
    a_neg_s  = sgn_s & a[31];
    b_neg_s  = sgn_s & b[31];
    // Low 64 bits of the extended product are correct for both signednesses.
    prod     = {{32{a_neg_s}}, a} * {{32{b_neg_s}}, b};
    a_mag_s  = a_neg_s ? (32'd0 - a) : a;
    b_mag_s  = b_neg_s ? (32'd0 - b) : b;
    div_zero = (b == 32'd0);
    if (div_zero) begin
      q_mag_s = 32'd0;
      r_mag_s = 32'd0;
    end else begin
      q_mag_s = a_mag_s / b_mag_s;
      r_mag_s = a_mag_s % b_mag_s;
    end
    quot = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
    rem  = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide controller owning HI/LO.
//   clk, reset : clock and synchronous active-high reset
//   bus        : md_unit_if.slave -- E-stage request (start/md_op/src_a/src_b),
//                D-stage md_use_D, and HI/LO/busy/stall_req back to the pipe.
// Results are computed at the start edge, parked in a pending register, and
// committed to HI/LO at the edge that closes the fixed busy window.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  md_state_e          state_r, state_nxt_s;
  logic [CNT_W-1:0]   count_r, count_nxt_s;
  logic [31:0]        hi_r, hi_nxt_s;
  logic [31:0]        lo_r, lo_nxt_s;
  logic [31:0]        pend_hi_r, pend_hi_nxt_s;
  logic [31:0]        pend_lo_r, pend_lo_nxt_s;
  logic               pend_wr_r, pend_wr_nxt_s;
  logic               stall_s;

  logic [63:0]        prod_s;
  logic [31:0]        quot_s;
  logic [31:0]        rem_s;
  logic               div_zero_s;

  md_datapath u_datapath (
    .op       (bus.md_op),
    .a        (bus.src_a),
    .b        (bus.src_b),
    .prod     (prod_s),
    .quot     (quot_s),
    .rem      (rem_s),
    .div_zero (div_zero_s)
  );

  // State register: controller state, counter, pending result and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      count_r   <= '0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      hi_r      <= hi_nxt_s;
      lo_r      <= lo_nxt_s;
      pend_hi_r <= pend_hi_nxt_s;
      pend_lo_r <= pend_lo_nxt_s;
      pend_wr_r <= pend_wr_nxt_s;
    end
  end

  // Next-state logic: starts are only accepted in IDLE; BUSY counts down and
  // commits the pending result on its last cycle.
  always_comb begin
    state_nxt_s   = state_r;
    count_nxt_s   = count_r;
    hi_nxt_s      = hi_r;
    lo_nxt_s      = lo_r;
    pend_hi_nxt_s = pend_hi_r;
    pend_lo_nxt_s = pend_lo_r;
    pend_wr_nxt_s = pend_wr_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.md_op)
            MD_MULT, MD_MULTU: begin
              pend_hi_nxt_s = prod_s[63:32];
              pend_lo_nxt_s = prod_s[31:0];
              pend_wr_nxt_s = 1'b1;
              count_nxt_s   = CNT_W'(MULT_CYCLES);
              state_nxt_s   = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_nxt_s = rem_s;
              pend_lo_nxt_s = quot_s;
              // Divide by zero still burns the window but leaves HI/LO alone.
              pend_wr_nxt_s = ~div_zero_s;
              count_nxt_s   = CNT_W'(DIV_CYCLES);
              state_nxt_s   = ST_BUSY;
            end
            MD_MTHI: hi_nxt_s = bus.src_a;
            MD_MTLO: lo_nxt_s = bus.src_a;
            default: ;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (count_r == CNT_W'(1)) begin
          if (pend_wr_r) begin
            hi_nxt_s = pend_hi_r;
            lo_nxt_s = pend_lo_r;
          end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
          end
          count_nxt_s = '0;
          state_nxt_s = ST_IDLE;
        end else begin
          count_nxt_s = count_r - CNT_W'(1);
        end
      end
      default: begin
        count_nxt_s = '0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: stall a D-stage md instruction while busy and in the cycle
  // a timed op is being launched from E.
  always_comb begin
    stall_s = 1'b0;
    if (bus.md_use_D && ((state_r == ST_BUSY) || (bus.start && is_timed_op(bus.md_op)))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  assign bus.HI        = hi_r;
  assign bus.LO        = lo_r;
  assign bus.busy      = (state_r == ST_BUSY);
  assign bus.stall_req = stall_s;

endmodule
